// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the write requesters, the FIFO write port and fifo_wr_arbiter.
// The arbiter takes the slave modport; the requester/FIFO side takes master.
interface fifo_wr_arbiter_if #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 16
);
  logic [NREQ-1:0]            req;
  logic [NREQ*DATA_WIDTH-1:0] req_data;
  logic [NREQ-1:0]            ack;
  logic [NREQ-1:0]            nack;
  logic                       fifo_wr_en;
  logic [DATA_WIDTH-1:0]      fifo_data_in;
  logic                       fifo_full;
  logic                       fifo_wr_ack;
  logic                       fifo_overflow;
  logic [7:0]                 drop_cnt;

  modport master (
    output req, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
    input  ack, nack, fifo_wr_en, fifo_data_in, drop_cnt
  );

  modport slave (
    input  req, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
    output ack, nack, fifo_wr_en, fifo_data_in, drop_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter funnelling NREQ write requesters into one FIFO write port,
// with overflow retry, ack timeout (nack) and a saturating drop counter.
module fifo_wr_arbiter #(
  parameter int NREQ        = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.slave   bus
);
  // states: IDLE arbitrate | ISSUE one-cycle wr_en | WAIT_ACK await ack/ovf/timeout | HOLD wait !full, retry same word
  localparam int IDX_W = $clog2(NREQ);
  localparam int TMR_W = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, HOLD} state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_win;
  logic [IDX_W-1:0]      r_last;
  logic [DATA_WIDTH-1:0] r_data;
  logic [TMR_W-1:0]      r_tmr;
  logic [NREQ-1:0]       r_ack;
  logic [NREQ-1:0]       r_nack;
  logic                  r_wr_en;
  logic [7:0]            r_drop;

  logic [IDX_W-1:0]      w_pick;
  logic [DATA_WIDTH-1:0] w_word;

  // Scan from farthest to nearest so the last hit is the first requester after r_last.
  always_comb begin
    int idx;
    idx    = 0;
    w_pick = r_last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(r_last) + k) % NREQ;
      if (bus.req[IDX_W'(idx)]) w_pick = IDX_W'(idx);
    end
  end

  always_comb begin
    w_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick == IDX_W'(i)) w_word = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_win   <= '0;
      r_last  <= IDX_W'(NREQ - 1);
      r_data  <= '0;
      r_tmr   <= '0;
      r_ack   <= '0;
      r_nack  <= '0;
      r_wr_en <= 1'b0;
      r_drop  <= '0;
    end else begin
      r_ack   <= '0;
      r_nack  <= '0;
      r_wr_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|bus.req && !bus.fifo_full) begin
            r_win   <= w_pick;
            r_data  <= w_word;
            r_wr_en <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_tmr   <= TMR_W'(ACK_TIMEOUT - 1);
          r_state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (bus.fifo_wr_ack) begin
            r_ack   <= NREQ'(1) << r_win;
            r_last  <= r_win;
            r_state <= IDLE;
          end else if (bus.fifo_overflow) begin
            r_state <= HOLD;
          end else if (r_tmr == '0) begin
            r_nack  <= NREQ'(1) << r_win;
            r_last  <= r_win;
            if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
            r_state <= IDLE;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        HOLD: begin
          if (!bus.fifo_full) begin
            r_wr_en <= 1'b1;
            r_state <= ISSUE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ack          = r_ack;
  assign bus.nack         = r_nack;
  assign bus.fifo_wr_en   = r_wr_en;
  assign bus.fifo_data_in = r_data;
  assign bus.drop_cnt     = r_drop;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed corner sequences, a vector table of single
// transactions, and a random phase checked against a deadline-based reference model.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int T    = 4;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] word;
    int          dly;
    logic [3:0]  ack;
    logic [3:0]  nack;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [DW-1:0] word [NREQ];
  int cyc, n_chk, n_err;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .ACK_TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.req_data = {word[3], word[2], word[1], word[0]};

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.fifo_wr_ack = 1'b0;
    bus.fifo_overflow = 1'b0;
    bus.fifo_full = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_wr(input string nm, output int w);
    w = -100;
    for (int k = 0; k < 40; k++) begin
      if (bus.fifo_wr_en) begin
        w = cyc;
        return;
      end
      tick();
    end
    n_chk++;
    n_err++;
    $display("FAIL %s: no fifo_wr_en within 40 cycles (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] r;
    r = '0;
    r[i[1:0]] = 1'b1;
    return r;
  endfunction

  function automatic int rr_pick(input logic [3:0] r, input int last);
    int j;
    for (int k = 1; k <= NREQ; k++) begin
      j = (last + k) % NREQ;
      if (r[j[1:0]]) return j;
    end
    return 0;
  endfunction

  task automatic run_txn(input vec_t v);
    int n, w, o, win;
    logic [3:0] m;
    m = v.ack | v.nack;
    win = 0;
    for (int i = 0; i < NREQ; i++) if (m[i]) win = i;
    for (int i = 0; i < NREQ; i++) word[i] = (i == win) ? v.word : (~v.word ^ 16'(i));
    bus.req = v.req;
    n = cyc;
    wait_wr("tbl_wr", w);
    chk("tbl_wr_lat", w - n, 1);
    chk("tbl_data", bus.fifo_data_in, v.word);
    if (v.dly > 0) begin
      repeat (v.dly) tick();
      bus.fifo_wr_ack = 1'b1;
      tick();
      bus.fifo_wr_ack = 1'b0;
    end
    o = -1;
    for (int k = 0; k < 30; k++) begin
      if (|bus.ack || |bus.nack) begin
        o = cyc;
        break;
      end
      tick();
    end
    chk("tbl_ack", bus.ack, v.ack);
    chk("tbl_nack", bus.nack, v.nack);
    chk("tbl_lat", o - n, v.lat);
    bus.req = '0;
    tick();
    chk("tbl_pulse", {bus.ack, bus.nack}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    vec_t tmo;
    int ord [5];
    int w;
    logic [3:0]  e_ack, e_nack;
    logic        e_wr;
    logic [15:0] e_data, m_word;
    int m_last, m_win, m_wr_cyc, m_drop, kind, resp_cyc, hold_len;
    bit m_busy, m_hold;

    tbl[0] = '{4'b0100, 16'hA5A5, 1, 4'b0100, 4'b0000, 3};
    tbl[1] = '{4'b1010, 16'h1234, 1, 4'b1000, 4'b0000, 3};
    tbl[2] = '{4'b1010, 16'h2345, 2, 4'b0010, 4'b0000, 4};
    tbl[3] = '{4'b1001, 16'h3456, 4, 4'b1000, 4'b0000, 6};
    tbl[4] = '{4'b0011, 16'h4567, 1, 4'b0001, 4'b0000, 3};
    tbl[5] = '{4'b0001, 16'h5678, 0, 4'b0000, 4'b0001, 2 + T};
    tbl[6] = '{4'b0011, 16'h6789, 3, 4'b0010, 4'b0000, 5};
    tbl[7] = '{4'b1100, 16'h789A, 1, 4'b0100, 4'b0000, 3};
    tmo    = '{4'b0001, 16'h1111, 0, 4'b0000, 4'b0001, 2 + T};
    ord    = '{0, 1, 2, 3, 0};

    n_chk = 0;
    n_err = 0;
    cyc = 0;
    for (int i = 0; i < NREQ; i++) word[i] = '0;
    rst = 1'b1;
    bus.req = 4'b1111;
    bus.fifo_full = 1'b0;
    bus.fifo_wr_ack = 1'b0;
    bus.fifo_overflow = 1'b0;

    // requests held high throughout reset must not leak out
    repeat (4) begin
      tick();
      chk("rst_wr_en", bus.fifo_wr_en, 0);
      chk("rst_ack", bus.ack, 0);
      chk("rst_nack", bus.nack, 0);
      chk("rst_drop", bus.drop_cnt, 0);
    end
    bus.req = '0;
    rst = 1'b0;
    tick();

    for (int i = 0; i < NREQ; i++) word[i] = 16'h1000 + 16'(i);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_wr("fair_wr", w);
      chk("fair_data", bus.fifo_data_in, 16'h1000 + 16'(ord[k]));
      tick();
      bus.fifo_wr_ack = 1'b1;
      tick();
      bus.fifo_wr_ack = 1'b0;
      chk("fair_ack", bus.ack, onehot(ord[k]));
    end
    bus.req = '0;
    tick();

    do_reset();
    for (int r = 0; r < 8; r++) run_txn(tbl[r]);
    chk("tbl_drop_cnt", bus.drop_cnt, 1);

    word[0] = 16'hBEEF;
    bus.fifo_full = 1'b1;
    bus.req = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("full_no_wr", bus.fifo_wr_en, 0);
    end
    bus.fifo_full = 1'b0;
    tick();
    chk("full_release_wr", bus.fifo_wr_en, 1);
    chk("full_release_data", bus.fifo_data_in, 16'hBEEF);
    tick();
    bus.fifo_wr_ack = 1'b1;
    tick();
    bus.fifo_wr_ack = 1'b0;
    chk("full_ack", bus.ack, 4'b0001);
    bus.req = '0;
    tick();

    word[1] = 16'hC0DE;
    bus.req = 4'b0010;
    wait_wr("ovf_wr", w);
    chk("ovf_first_data", bus.fifo_data_in, 16'hC0DE);
    tick();
    bus.fifo_overflow = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.fifo_overflow = 1'b0;
      bus.fifo_full = 1'b1;
      chk("ovf_hold_no_wr", bus.fifo_wr_en, 0);
    end
    tick();
    bus.fifo_full = 1'b0;
    chk("ovf_hold_no_wr", bus.fifo_wr_en, 0);
    chk("ovf_no_ack", {bus.ack, bus.nack}, 0);
    tick();
    chk("ovf_retry_wr", bus.fifo_wr_en, 1);
    chk("ovf_retry_data", bus.fifo_data_in, 16'hC0DE);
    tick();
    bus.fifo_wr_ack = 1'b1;
    tick();
    bus.fifo_wr_ack = 1'b0;
    chk("ovf_ack", bus.ack, 4'b0010);
    chk("ovf_nack", bus.nack, 4'b0000);
    bus.req = '0;
    tick();

    do_reset();
    run_txn(tmo);
    chk("tmo_drop_1", bus.drop_cnt, 1);
    for (int k = 0; k < 299; k++) run_txn(tmo);
    chk("tmo_drop_sat", bus.drop_cnt, 255);

    // reset in the middle of a write abandons it silently
    do_reset();
    word[0] = 16'h5555;
    bus.req = 4'b0001;
    wait_wr("midrst_wr", w);
    #2 rst = 1'b1;
    #1;
    chk("midrst_async_wr_en", bus.fifo_wr_en, 0);
    chk("midrst_async_data", bus.fifo_data_in, 0);
    bus.req = '0;
    tick();
    rst = 1'b0;
    bus.fifo_wr_ack = 1'b1;
    tick();
    bus.fifo_wr_ack = 1'b0;
    repeat (5) begin
      chk("midrst_no_ack", bus.ack, 0);
      chk("midrst_no_nack", bus.nack, 0);
      tick();
    end

    do_reset();
    e_ack = '0; e_nack = '0; e_wr = 1'b0; e_data = '0; m_word = '0;
    m_last = NREQ - 1; m_win = 0; m_wr_cyc = 0; m_drop = 0;
    m_busy = 1'b0; m_hold = 1'b0;
    kind = 0; resp_cyc = -1; hold_len = 0;
    for (int t = 0; t < 3000; t++) begin
      tick();
      chk("rnd_wr_en", bus.fifo_wr_en, e_wr);
      if (e_wr) chk("rnd_data", bus.fifo_data_in, e_data);
      chk("rnd_ack", bus.ack, e_ack);
      chk("rnd_nack", bus.nack, e_nack);
      chk("rnd_drop", bus.drop_cnt, m_drop);

      if (e_wr) begin
        kind = $urandom_range(0, 7);
        resp_cyc = cyc + ((kind == 7) ? T : $urandom_range(1, T));
        hold_len = $urandom_range(0, 3);
      end
      bus.req = bus.req & ~(e_ack | e_nack);
      if (m_busy && $urandom_range(0, 15) == 0) bus.req[m_win] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req[i] && !(m_busy && i == m_win) && $urandom_range(0, 2) == 0) begin
          bus.req[i] = 1'b1;
          word[i] = 16'($urandom);
        end
      end
      bus.fifo_wr_ack   = (cyc == resp_cyc) && (kind <= 3 || kind == 5 || kind == 7);
      bus.fifo_overflow = (cyc == resp_cyc) && (kind == 4 || kind == 5);
      if (kind == 4 && cyc > resp_cyc && cyc <= resp_cyc + hold_len) bus.fifo_full = 1'b1;
      else bus.fifo_full = ($urandom_range(0, 3) == 0);

      e_wr = 1'b0;
      e_ack = '0;
      e_nack = '0;
      if (!m_busy) begin
        if (|bus.req && !bus.fifo_full) begin
          m_win = rr_pick(bus.req, m_last);
          m_word = word[m_win];
          m_busy = 1'b1;
          e_wr = 1'b1;
          e_data = m_word;
          m_wr_cyc = cyc + 1;
        end
      end else if (m_hold) begin
        if (!bus.fifo_full) begin
          m_hold = 1'b0;
          e_wr = 1'b1;
          e_data = m_word;
          m_wr_cyc = cyc + 1;
        end
      end else if (cyc > m_wr_cyc) begin
        if (bus.fifo_wr_ack) begin
          e_ack = onehot(m_win);
          m_last = m_win;
          m_busy = 1'b0;
        end else if (bus.fifo_overflow) begin
          m_hold = 1'b1;
        end else if (cyc - m_wr_cyc == T) begin
          e_nack = onehot(m_win);
          m_last = m_win;
          m_busy = 1'b0;
          if (m_drop < 255) m_drop++;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning number of write requesters (2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning FIFO data word width.
REQ-003 The block SHALL have parameter ACK_TIMEOUT, default 4, meaning cycles to wait for FIFO wr_ack/overflow after a write.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high; port clk  input  1  rising-edge clock shared with the FIFO.
REQ-005 The block SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 The block SHALL have port req  input  NREQ  per-requester write request, held high with stable data until ack or nack.
REQ-007 The block SHALL have port req_data  input  NREQ*DATA_WIDTH  requester i word in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port ack  output  NREQ  one-cycle pulse: requester i word written to the FIFO.
REQ-009 The block SHALL have port nack  output  NREQ  one-cycle pulse: requester i word dropped after timeout.
REQ-010 The block SHALL have port fifo_wr_en  output  1  FIFO write enable.
REQ-011 The block SHALL have port fifo_data_in  output  DATA_WIDTH  FIFO write data.
REQ-012 The block SHALL have ports fifo_full, fifo_wr_ack, fifo_overflow  input  1 each  FIFO status.
REQ-013 The block SHALL have port drop_cnt  output  8  saturating count of nack events.

Function
REQ-014 The block SHALL implement FSM states IDLE, ISSUE, WAIT_ACK, HOLD; all outputs registered.
REQ-015 In IDLE with any req high and fifo_full low, the block SHALL select a winner round-robin starting at index (last_winner+1) mod NREQ, latch its index and data, and enter ISSUE.
REQ-016 In IDLE with fifo_full high, the block SHALL stay in IDLE and assert no write.
REQ-017 In ISSUE the block SHALL drive fifo_wr_en=1 and fifo_data_in=latched data for exactly one cycle, clear the timeout counter, then enter WAIT_ACK.
REQ-018 In WAIT_ACK on fifo_wr_ack=1, the block SHALL pulse ack[winner] the next cycle, set last_winner=winner, and return to IDLE.
REQ-019 In WAIT_ACK on fifo_overflow=1, the block SHALL enter HOLD with the winner and data kept locked (no re-arbitration).
REQ-020 In HOLD the block SHALL wait until fifo_full=0, then enter ISSUE to retry the same word.
REQ-021 If wr_ack and overflow are both high in the same cycle, the block SHALL treat it as wr_ack.
REQ-022 If WAIT_ACK lasts ACK_TIMEOUT cycles with neither input, the block SHALL pulse nack[winner], increment drop_cnt (saturating at 255), set last_winner=winner, and return to IDLE.
REQ-023 Minimum latency SHALL be: req sampled in IDLE at cycle N, fifo_wr_en at N+1, ack pulse at cycle after fifo_wr_ack (N+3 with single-cycle FIFO ack).
REQ-024 At most one of ack/nack bits SHALL be high in any cycle; fifo_wr_en SHALL never be high in two consecutive cycles.
REQ-025 A requester deasserting req while it is the winner SHALL NOT abort the in-flight write; ack/nack is still issued.

Reset
REQ-026 On rst high, the block SHALL immediately enter IDLE and drive fifo_wr_en=0, fifo_data_in=0, ack=0, nack=0, drop_cnt=0, last_winner=NREQ-1 (so requester 0 wins first).
REQ-027 Reset mid-write SHALL abandon the in-flight word with no ack or nack issued.

Verification
REQ-028 Reset: assert rst with req=4'b1111 -> fifo_wr_en=0, ack=0, nack=0, drop_cnt=0 throughout reset.
REQ-029 Single: req=4'b0100, data 16'hA5A5, FIFO acks one cycle after write -> one fifo_wr_en with 16'hA5A5, ack=4'b0100 at N+3.
REQ-030 Fairness: req=4'b1111 held, always acked -> write order 0,1,2,3,0; no requester served twice before others.
REQ-031 Full: fifo_full=1 with req=4'b0001 for 10 cycles -> no fifo_wr_en; release full -> write issues next cycle.
REQ-032 Overflow retry: first write answered by overflow, fifo_full high 3 cycles -> same data rewritten after full drops, then ack to same requester.
REQ-033 Timeout: FIFO never responds -> nack pulses after ACK_TIMEOUT cycles, drop_cnt=1; 300 timeouts -> drop_cnt=255.
